// File: rtl/hazard_forward_unit.sv
// Operand forwarding select and load-use stall generation for the EX stage,
// with saturating hazard statistics.
module hazard_forward_unit #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned NUM_STG  = 2,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned SEL_W    = $clog2(NUM_STG + 1),
    parameter int unsigned CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC*ADDR_W-1:0]  ex_rs,
    input  logic [NUM_STG*ADDR_W-1:0]  stg_rd,
    input  logic [NUM_STG-1:0]         stg_we,
    input  logic [NUM_STG-1:0]         stg_rdy,
    input  logic                       id_valid,
    input  logic [NUM_SRC*ADDR_W-1:0]  id_rs,
    input  logic [ADDR_W-1:0]          ex_rd,
    input  logic                       ex_we,
    input  logic                       ex_is_load,
    input  logic                       flush,
    input  logic                       clr_stats,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
    output logic                       stall,
    output logic                       bubble,
    output logic                       fwd_err,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           fwd_cnt
);

    localparam int unsigned LAT_W_RAW = $clog2(LOAD_LAT + 1);
    localparam int unsigned LAT_W     = (LAT_W_RAW > 2) ? LAT_W_RAW : 2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_SRC-1:0] pend;
    logic               rs_match;
    logic               hit;

    // Forward select: scan oldest to youngest so the youngest match overrides.
    always_comb begin
        fwd_sel = '0;
        pend    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = NUM_STG - 1; k >= 0; k--) begin
                if (stg_we[k] && (stg_rd[k*ADDR_W +: ADDR_W] != '0) &&
                    (stg_rd[k*ADDR_W +: ADDR_W] == ex_rs[i*ADDR_W +: ADDR_W])) begin
                    fwd_sel[i*SEL_W +: SEL_W] = stg_rdy[k] ? SEL_W'(k + 1) : '0;
                    pend[i]                   = ~stg_rdy[k];
                end
            end
        end
    end

    // Load-use detection against the instruction in ID.
    always_comb begin
        rs_match = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_rs[i*ADDR_W +: ADDR_W] == ex_rd) begin
                rs_match = 1'b1;
            end
        end
    end

    assign hit = id_valid & ex_is_load & ex_we & (ex_rd != '0) & rs_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stall FSM: first stall cycle is in IDLE, the remaining LOAD_LAT-1 in HOLD.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit && !flush) begin
                    stall = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = HOLD;
                        cnt_d   = LAT_W'(LOAD_LAT - 1);
                    end
                end
            end
            HOLD: begin
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q - LAT_W'(1);
                    if (cnt_q == LAT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bubble = stall;

    // Sticky error and saturating statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_err   <= 1'b0;
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if ((|pend) && !stall) begin
                fwd_err <= 1'b1;
            end
            if (clr_stats) begin
                stall_cnt <= '0;
                fwd_cnt   <= '0;
            end else begin
                if (stall && (stall_cnt != '1)) begin
                    stall_cnt <= stall_cnt + CNT_W'(1);
                end
                if ((|fwd_sel) && (fwd_cnt != '1)) begin
                    fwd_cnt <= fwd_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
